// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared defaults and types for the router output port.
//   DEPTH        : FIFO entries (power of two)
//   DW           : byte width
//   TIMEOUT      : consecutive unread valid cycles before a soft reset
//   fifo_entry_t : one stored FIFO entry, {header flag, byte}
// -----------------------------------------------------------------------------
package router_pkg;

  localparam int DEPTH   = 16;
  localparam int DW      = 8;
  localparam int TIMEOUT = 30;

  typedef struct packed {
    logic          hdr;   // entry was written with lfd_state=1
    logic [DW-1:0] data;
  } fifo_entry_t;

endpackage : router_pkg

// File: rtl/router_out_port_if.sv
// -----------------------------------------------------------------------------
// router_out_port_if
// Bundles the write, read and status signals of one router output port.
//   master : router core / destination side (drives write and read requests)
//   slave  : the output port itself (drives data_out and status flags)
// Signals:
//   write_enb, data_in, lfd_state : write request, byte, header marker
//   read_enb                      : read request from the destination
//   data_out                      : registered read data
//   vld_out, full, empty          : occupancy status
//   soft_reset                    : one-cycle pulse on read timeout
// -----------------------------------------------------------------------------
interface router_out_port_if;
  import router_pkg::*;

  logic          write_enb;
  logic [DW-1:0] data_in;
  logic          lfd_state;
  logic          read_enb;
  logic [DW-1:0] data_out;
  logic          vld_out;
  logic          full;
  logic          empty;
  logic          soft_reset;

  modport master (
    output write_enb, data_in, lfd_state, read_enb,
    input  data_out, vld_out, full, empty, soft_reset
  );

  modport slave (
    input  write_enb, data_in, lfd_state, read_enb,
    output data_out, vld_out, full, empty, soft_reset
  );

endinterface : router_out_port_if

// File: rtl/router_fifo.sv
// -----------------------------------------------------------------------------
// router_fifo
// Storage, pointers and occupancy for the output port.
// Ports:
//   clock, resetn : clock, synchronous active-low reset
//   i_clear       : soft clear; empties the FIFO and discards this cycle's
//                   read and write requests
//   i_wr_req      : write request, i_wr_entry is the entry to store
//   i_rd_req      : read request
//   o_rd_entry    : entry at the read pointer (combinational)
//   o_rd_accept   : the read request is accepted at this edge
//   o_full/o_empty: occupancy == DEPTH / occupancy == 0
// -----------------------------------------------------------------------------
module router_fifo
  import router_pkg::fifo_entry_t;
#(
  parameter int DEPTH = router_pkg::DEPTH
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        i_clear,
  input  logic        i_wr_req,
  input  fifo_entry_t i_wr_entry,
  input  logic        i_rd_req,
  output fifo_entry_t o_rd_entry,
  output logic        o_rd_accept,
  output logic        o_full,
  output logic        o_empty
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  fifo_entry_t   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_wr_acc;
  logic          w_rd_acc;

  // Flags come from pre-edge occupancy, so a read+write at full only reads
  // and a read+write at empty only writes.
  assign o_full      = (r_count == FULL_CNT);
  assign o_empty     = (r_count == '0);
  assign w_wr_acc    = i_wr_req & ~o_full  & ~i_clear;
  assign w_rd_acc    = i_rd_req & ~o_empty & ~i_clear;
  assign o_rd_accept = w_rd_acc;
  assign o_rd_entry  = r_mem[r_rd_ptr];

  // NOTE: the storage array is deliberately left out of reset; occupancy
  // alone decides what is valid, and an unreset array maps onto plain RAM.
  always_ff @(posedge clock) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= i_wr_entry;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (!resetn || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : router_fifo

// File: rtl/router_out_port.sv
// -----------------------------------------------------------------------------
// router_out_port
// One router output port: a FIFO of {header flag, byte} entries, a packet
// counter that zeroes data_out between packets, and a read-timeout watchdog
// that soft-resets the port when a destination stops reading.
// Ports:
//   clock, resetn : clock, synchronous active-low reset
//   bus (slave)   : write_enb/data_in/lfd_state in, read_enb in,
//                   data_out/vld_out/full/empty/soft_reset out
// -----------------------------------------------------------------------------
module router_out_port
  import router_pkg::fifo_entry_t;
#(
  parameter int DEPTH   = router_pkg::DEPTH,
  parameter int DW      = router_pkg::DW,
  parameter int TIMEOUT = router_pkg::TIMEOUT
) (
  input  logic              clock,
  input  logic              resetn,
  router_out_port_if.slave  bus
);

  localparam int          PW      = DW - 2;            // packet length field width
  localparam int          TW      = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  fifo_entry_t   w_wr_entry;
  fifo_entry_t   w_rd_entry;
  logic          w_rd_accept;
  logic          w_full;
  logic          w_empty;
  logic          w_idle;
  logic [DW-1:0] r_data_out;
  logic [PW-1:0] r_pkt_cnt;
  logic [TW-1:0] r_idle_cnt;
  logic          r_soft_reset;

  assign w_wr_entry = '{hdr: bus.lfd_state, data: bus.data_in};

  router_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock       (clock),
    .resetn      (resetn),
    .i_clear     (r_soft_reset),
    .i_wr_req    (bus.write_enb),
    .i_wr_entry  (w_wr_entry),
    .i_rd_req    (bus.read_enb),
    .o_rd_entry  (w_rd_entry),
    .o_rd_accept (w_rd_accept),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // A cycle counts toward the timeout only while data waits and nobody reads.
  assign w_idle = ~w_empty & ~bus.read_enb;

  // NOTE: sequential state is assigned with <= so every register samples
  // pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge clock) begin
    if (!resetn || r_soft_reset || !w_idle) begin
      r_idle_cnt   <= '0;
      r_soft_reset <= 1'b0;
    end else if (r_idle_cnt == TO_LAST) begin
      r_idle_cnt   <= '0;
      r_soft_reset <= 1'b1;
    end else begin
      r_idle_cnt   <= r_idle_cnt + TW'(1);
      r_soft_reset <= 1'b0;
    end
  end

  // Header bytes carry the payload length in [7:2]; +1 covers the parity byte.
  // Once the packet is fully read, an idle cycle drives data_out back to zero.
  always_ff @(posedge clock) begin
    if (!resetn || r_soft_reset) begin
      r_pkt_cnt  <= '0;
      r_data_out <= '0;
    end else if (w_rd_accept) begin
      r_data_out <= w_rd_entry.data;
      if (w_rd_entry.hdr)
        r_pkt_cnt <= w_rd_entry.data[DW-1:2] + PW'(1);
      else if (r_pkt_cnt != '0)
        r_pkt_cnt <= r_pkt_cnt - PW'(1);
    end else if (r_pkt_cnt == '0) begin
      r_data_out <= '0;
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.vld_out    = ~w_empty;
  assign bus.full       = w_full;
  assign bus.empty      = w_empty;
  assign bus.soft_reset = r_soft_reset;

endmodule : router_out_port

// File: doc/router_out_port.md
ROUTER_OUT_PORT -- requirements
Module: router_out_port

Interface
REQ-001 Parameters: DEPTH, default 16, FIFO entries (power of two); DW, default 8, byte width; TIMEOUT, default 30, idle-read cycles before soft reset.
REQ-002 clock  input  1  single rising-edge clock for all state.
REQ-003 resetn  input  1  synchronous, active-low reset.
REQ-004 write_enb  input  1  write request from the router core.
REQ-005 data_in  input  8  byte to store.
REQ-006 lfd_state  input  1  high with write_enb marks data_in as a packet header byte.
REQ-007 read_enb  input  1  read request from the destination reader.
REQ-008 data_out  output  8  registered read data to the destination.
REQ-009 vld_out  output  1  FIFO holds at least one byte.
REQ-010 full  output  1  occupancy == DEPTH.
REQ-011 empty  output  1  occupancy == 0.
REQ-012 soft_reset  output  1  one-cycle pulse on read timeout.

Function
REQ-013 Storage: DEPTH entries x 9 bits, {header flag, byte}; 4-bit read/write pointers wrap DEPTH-1 -> 0; 5-bit occupancy counter 0..16.
REQ-014 Write accepted on a clock edge iff write_enb=1, full=0 and soft_reset=0; stores {lfd_state, data_in}, write pointer +1.
REQ-015 Read accepted iff read_enb=1 and empty=0; data_out <= stored byte at the next edge (1-cycle latency); read pointer +1.
REQ-016 full/empty are evaluated from pre-edge occupancy: at full, simultaneous read+write accepts the read only; at empty, simultaneous read+write accepts the write only; otherwise simultaneous read+write leaves occupancy unchanged.
REQ-017 vld_out = ~empty, combinational from occupancy.
REQ-018 Packet counter (6 bits): a read of a header entry loads count = byte[7:2] + 1 (payload plus parity); each later read of a non-header entry decrements count; no decrement below 0.
REQ-019 data_out <= 8'h00 at an edge where no read is accepted and count == 0; otherwise data_out holds its value when no read is accepted.
REQ-020 Timeout counter (5 bits): +1 each cycle with vld_out=1 and read_enb=0; cleared when read_enb=1 or vld_out=0.
REQ-021 soft_reset = 1 for exactly the cycle after the timeout counter reaches TIMEOUT-1 (TIMEOUT consecutive unread valid cycles), then timeout counter clears.
REQ-022 When soft_reset=1: at that edge pointers, occupancy, packet count clear, data_out <= 8'h00; any concurrent write or read is discarded.

Reset
REQ-023 On resetn=0 at a rising edge: pointers, occupancy, packet count, timeout counter = 0; data_out = 8'h00; soft_reset = 0; hence empty=1, full=0, vld_out=0 the following cycle.
REQ-024 Reset mid-packet or mid-timeout discards all stored data; memory contents need not clear.

Structure
REQ-025 Package router_pkg holds DEPTH, DW, TIMEOUT defaults and the 9-bit FIFO entry typedef.
REQ-026 Storage, pointers and occupancy live in one sub-module router_fifo; packet count, data_out zeroing and timeout logic live in router_out_port.

Verification
REQ-027 Write header 8'h0C (lfd=1), payload 8'hA1,8'hA2,8'hA3, parity 8'h5E; read continuously -> data_out 0C,A1,A2,A3,5E on consecutive cycles one edge after each read, then 8'h00; vld_out falls after the 5th read.
REQ-028 Write 16 bytes with no reads -> full=1 after the 16th; 17th write ignored; reading all returns the 16 bytes in order, empty=1 after the 16th read.
REQ-029 At full, assert read_enb and write_enb together -> occupancy stays 15 after the edge, written byte not stored; at empty, both together -> occupancy 1, data_out unchanged.
REQ-030 Write one byte, hold read_enb=0 -> soft_reset pulses high exactly in the 31st cycle after vld_out rose, then empty=1, data_out=8'h00; a read_enb pulse in cycle 20 restarts the count.
REQ-031 Write 20 bytes, read 20 across pointer wrap with interleaved writes -> data order preserved, no spurious full/empty.
REQ-032 Assert resetn=0 mid-packet with 5 bytes stored -> next cycle empty=1, vld_out=0, data_out=8'h00, soft_reset=0.
